// File: rtl/cdc_2phase_dst_buf_pkg.sv
// Shared helpers for the buffered 2-phase CDC destination.
// Pointer arithmetic for FIFOs whose depth need not be a power of two.
package cdc_2phase_dst_buf_pkg;

   function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
      return (p + 1 >= depth) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/cdc_2phase_dst_buf_sync.sv
// Multi-stage level synchronizer with asynchronous active-high reset.
// Stages are flagged ASYNC_REG so they are kept, packed together and not optimised away.
module sync_2ff_arst_hi #(
   parameter int SYNC = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC-1:0] r_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC-2:0], d_i};
      end
   end

   assign q_o = r_sync[SYNC-1];

endmodule

// File: rtl/cdc_2phase_dst_buf.sv
// Buffered destination half of a 2-phase req/ack/data CDC handshake.
// Each request is captured into a DEPTH-entry FIFO and acknowledged at capture time.
module cdc_2phase_dst_buf
   import cdc_2phase_dst_buf_pkg::*;
#(
   parameter type T     = logic,
   parameter int  DEPTH = 4,
   parameter int  SYNC  = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         async_req_i,
   output logic                         async_ack_o,
   input  T                             async_data_i,
   output T                             data_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic          w_req_s;
   logic          w_pend;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          r_ack;
   logic [CW-1:0] r_fill;
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   T              r_mem [DEPTH];

   sync_2ff_arst_hi #(
      .SYNC (SYNC)
   ) u_req_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (async_req_i),
      .q_o   (w_req_s)
   );

   // Full is judged on the registered count only, so ready_i never reaches the ack path.
   assign w_pend = w_req_s ^ r_ack;
   assign w_full = (r_fill == CW'(DEPTH));
   assign w_push = w_pend & ~w_full;
   assign w_pop  = valid_o & ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ack  <= 1'b0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_fill <= '0;
      end else begin
         if (w_push) begin
            r_ack  <= ~r_ack;
            r_wptr <= CW'(wrap_inc(32'(r_wptr), $unsigned(DEPTH)));
         end
         if (w_pop) begin
            r_rptr <= CW'(wrap_inc(32'(r_rptr), $unsigned(DEPTH)));
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == CW'(i))) begin
               r_mem[i] <= async_data_i;
            end
         end
      end
   end

   // Show-ahead read: the head entry is presented without an extra register stage.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_rptr == CW'(i)) begin
            data_o = r_mem[i];
         end
      end
   end

   assign valid_o     = (r_fill != '0);
   assign fill_o      = r_fill;
   assign async_ack_o = r_ack;

endmodule

// File: tb/tb_cdc_2phase_dst_buf.sv
// Randomised bench for cdc_2phase_dst_buf against a queue-based transaction model.
// Two instances (DEPTH 4 and 3) share stimulus; m_depth selects which one is checked.
module tb_cdc_2phase_dst_buf;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst;
   logic       req;
   logic       ready;
   logic [7:0] data;
   logic       ack4, valid4, ack3, valid3;
   logic [7:0] dout4, dout3;
   logic [2:0] fill4;
   logic [1:0] fill3;

   int n_tests;
   int n_fail;

   // Transaction model: FIFO contents, handshake parity, edges since last req toggle
   int         m_depth;
   logic [7:0] mq[$];
   logic [7:0] popped[$];
   logic [7:0] sent[$];
   logic       m_req;
   logic       m_ack;
   int         m_since;
   int         d_ack_toggles;
   logic       prev_ack;
   int         max_fill;

   cdc_2phase_dst_buf #(.T(logic [7:0]), .DEPTH(4), .SYNC(SYNC)) dut4 (
      .clk_i(clk), .rst_i(rst), .async_req_i(req), .async_ack_o(ack4),
      .async_data_i(data), .data_o(dout4), .valid_o(valid4), .ready_i(ready), .fill_o(fill4));

   cdc_2phase_dst_buf #(.T(logic [7:0]), .DEPTH(3), .SYNC(SYNC)) dut3 (
      .clk_i(clk), .rst_i(rst), .async_req_i(req), .async_ack_o(ack3),
      .async_data_i(data), .data_o(dout3), .valid_o(valid3), .ready_i(ready), .fill_o(fill3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic obs_ack();
      return (m_depth == 4) ? ack4 : ack3;
   endfunction
   function automatic logic obs_valid();
      return (m_depth == 4) ? valid4 : valid3;
   endfunction
   function automatic int obs_fill();
      return (m_depth == 4) ? int'(fill4) : int'(fill3);
   endfunction
   function automatic logic [7:0] obs_data();
      return (m_depth == 4) ? dout4 : dout3;
   endfunction

   function automatic void model_reset();
      mq.delete();
      popped.delete();
      sent.delete();
      m_req         = 1'b0;
      m_ack         = 1'b0;
      m_since       = 0;
      d_ack_toggles = 0;
      prev_ack      = 1'b0;
      max_fill      = 0;
   endfunction

   // One clock edge: predict from the rules, advance, then compare at the falling edge
   task automatic tick();
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && ready;
      do_push = (m_req != m_ack) && (m_since >= SYNC) && (mq.size() < m_depth);
      @(posedge clk);
      if (do_pop) begin
         popped.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (do_push) begin
         mq.push_back(data);
         m_ack = ~m_ack;
      end
      m_since++;
      @(negedge clk);
      if (obs_ack() != prev_ack) d_ack_toggles++;
      prev_ack = obs_ack();
      if (obs_fill() > max_fill) max_fill = obs_fill();
      n_tests++;
      if (obs_ack() !== m_ack) begin
         n_fail++;
         $display("FAIL tick_ack t=%0t: got %b expected %b", $time, obs_ack(), m_ack);
      end
      n_tests++;
      if (obs_fill() != mq.size()) begin
         n_fail++;
         $display("FAIL tick_fill t=%0t: got %0d expected %0d", $time, obs_fill(), mq.size());
      end
      n_tests++;
      if (obs_valid() !== (mq.size() != 0)) begin
         n_fail++;
         $display("FAIL tick_valid t=%0t: got %b expected %b", $time, obs_valid(), mq.size() != 0);
      end
      if (mq.size() != 0) begin
         n_tests++;
         if (obs_data() !== mq[0]) begin
            n_fail++;
            $display("FAIL tick_data t=%0t: got %h expected %h", $time, obs_data(), mq[0]);
         end
      end
   endtask

   task automatic send(input logic [7:0] d);
      data    = d;
      req     = ~req;
      m_req   = req;
      m_since = 0;
   endtask

   task automatic wait_ack(input int budget, input bit rand_ready);
      int n = 0;
      while (obs_ack() !== req && n < budget) begin
         if (rand_ready) ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      n_tests++;
      if (obs_ack() !== req) begin
         n_fail++;
         $display("FAIL ack_timeout t=%0t: ack %b req %b", $time, obs_ack(), req);
      end
   endtask

   // Asserts reset between clock edges and checks outputs react without a clock
   task automatic do_reset();
      #2;
      rst   = 1'b1;
      req   = 1'b0;
      data  = 8'h00;
      ready = 1'b0;
      #1;
      n_tests++;
      if (obs_ack() !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", obs_ack()); end
      n_tests++;
      if (obs_valid() !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", obs_valid()); end
      n_tests++;
      if (obs_fill() != 0) begin n_fail++; $display("FAIL rst_fill: got %0d expected 0", obs_fill()); end
      n_tests++;
      if (obs_data() !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", obs_data()); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      m_depth = 4;
      send(8'h3C);
      wait_ack(20, 1'b0);
      do_reset();
   endtask

   task automatic test_single();
      ready = 1'b0;
      send(8'hA5);
      tick();
      tick();
      n_tests++;
      if (ack4 !== 1'b0) begin n_fail++; $display("FAIL single_early_ack: got %b expected 0", ack4); end
      tick();
      n_tests++;
      if (ack4 !== req) begin n_fail++; $display("FAIL single_ack: got %b expected %b", ack4, req); end
      n_tests++;
      if (valid4 !== 1'b1 || dout4 !== 8'hA5 || fill4 !== 3'd1) begin
         n_fail++;
         $display("FAIL single_head: got v=%b d=%h f=%0d expected v=1 d=a5 f=1", valid4, dout4, fill4);
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_tests++;
      if (valid4 !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid %b expected 0", valid4); end
      repeat (3) tick();
      n_tests++;
      if (fill4 !== 3'd0 || ack4 !== req) begin
         n_fail++;
         $display("FAIL single_no_repush: got f=%0d ack=%b expected f=0 ack=%b", fill4, ack4, req);
      end
   endtask

   task automatic test_backpressure();
      popped.delete();
      d_ack_toggles = 0;
      prev_ack      = ack4;
      ready         = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(8'(i));
         wait_ack(20, 1'b0);
      end
      send(8'd5);
      repeat (6) tick();
      n_tests++;
      if (fill4 !== 3'd4) begin n_fail++; $display("FAIL bp_fill: got %0d expected 4", fill4); end
      n_tests++;
      if (ack4 === req) begin n_fail++; $display("FAIL bp_pending: got ack %b expected %b", ack4, ~req); end
   endtask

   task automatic test_full_pop();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      n_tests++;
      if (fill4 !== 3'd3 || ack4 === req) begin
         n_fail++;
         $display("FAIL fullpop_same: got f=%0d ack=%b expected f=3 ack=%b", fill4, ack4, ~req);
      end
      tick();
      n_tests++;
      if (fill4 !== 3'd4 || ack4 !== req) begin
         n_fail++;
         $display("FAIL fullpop_next: got f=%0d ack=%b expected f=4 ack=%b", fill4, ack4, req);
      end
   endtask

   task automatic test_drain();
      ready = 1'b1;
      send(8'd6);
      repeat (12) tick();
      n_tests++;
      if (popped.size() != 6) begin n_fail++; $display("FAIL drain_count: got %0d expected 6", popped.size()); end
      for (int i = 0; i < 6 && i < popped.size(); i++) begin
         n_tests++;
         if (popped[i] !== 8'(i + 1)) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: got %h expected %h", i, popped[i], 8'(i + 1));
         end
      end
      n_tests++;
      if (d_ack_toggles != 6) begin n_fail++; $display("FAIL drain_acks: got %0d expected 6", d_ack_toggles); end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      m_depth = 3;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         sent.push_back(d);
         send(d);
         wait_ack(60, 1'b1);
      end
      ready = 1'b1;
      repeat (8) tick();
      n_tests++;
      if (d_ack_toggles != 20) begin n_fail++; $display("FAIL wrap_acks: got %0d expected 20", d_ack_toggles); end
      n_tests++;
      if (max_fill > 3 || fill3 !== 2'd0) begin
         n_fail++;
         $display("FAIL wrap_fill: got max=%0d final=%0d expected max<=3 final=0", max_fill, fill3);
      end
      n_tests++;
      if (popped.size() != 20) begin n_fail++; $display("FAIL wrap_count: got %0d expected 20", popped.size()); end
      for (int i = 0; i < 20 && i < popped.size(); i++) begin
         n_tests++;
         if (popped[i] !== sent[i]) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: got %h expected %h", i, popped[i], sent[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      m_depth = 4;
      do_reset();
      send(8'h11);
      wait_ack(20, 1'b0);
      send(8'h22);
      wait_ack(20, 1'b0);
      send(8'h33);
      tick();
      tick();
      n_tests++;
      if (fill4 !== 3'd2 || ack4 === req) begin
         n_fail++;
         $display("FAIL mid_state: got f=%0d ack=%b expected f=2 ack=%b", fill4, ack4, ~req);
      end
      do_reset();
      test_single();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_depth = 4;
      rst     = 1'b1;
      req     = 1'b0;
      ready   = 1'b0;
      data    = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_full_pop();
      test_drain();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
